// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display, with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LOAD,
  output logic [3:0]            NIBBLE,
  output logic [DIGITS-1:0]     AN,
  output logic                  PENDING,
  output logic                  FRAME
);

  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int            IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  // With only one or two cycles per slot a blank cycle would eat most of the on-time.
  localparam bit            DEAD_EN   = (DIV > 2);

  logic [PW-1:0]       presc, presc_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*DIGITS-1:0] disp_reg, disp_nxt;
  logic [4*DIGITS-1:0] pend_reg, pend_nxt;
  logic                pending_nxt;
  logic                tick, boundary;
  logic [3:0]          nibble_nxt;
  logic [DIGITS-1:0]   an_nxt;
  logic [DIGITS-1:0]   lz_mask;

`ifdef SEG7_LZ_BLANK_EN
  // Digit k>0 is dark when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_reg[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // LOAD is a single-cycle strobe with no ready: VALUE is taken on every cycle LOAD is high,
  // held in pend_reg until the frame boundary, or written straight to the display if LOAD
  // coincides with the boundary. VALUE is ignored whenever LOAD is low.
  always_comb begin
    tick        = (presc == PRESC_MAX);
    boundary    = tick && (idx == IDX_MAX);
    presc_nxt   = tick ? '0 : presc + PW'(1);
    idx_nxt     = idx;
    disp_nxt    = disp_reg;
    pend_nxt    = pend_reg;
    pending_nxt = PENDING;

    if (tick) begin
      idx_nxt = (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end

    if (boundary) begin
      if (LOAD) begin
        disp_nxt = VALUE;
      end else if (PENDING) begin
        disp_nxt = pend_reg;
      end
      pending_nxt = 1'b0;
    end else if (LOAD) begin
      pend_nxt    = VALUE;
      pending_nxt = 1'b1;
    end

    nibble_nxt = disp_reg[4*idx +: 4];
    an_nxt     = ~(DIGITS'(1) << idx) | lz_mask;
    if (DEAD_EN && tick) begin
      an_nxt = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc    <= '0;
      idx      <= '0;
      disp_reg <= '0;
      pend_reg <= '0;
      PENDING  <= 1'b0;
      FRAME    <= 1'b0;
      NIBBLE   <= 4'h0;
      AN       <= '1;
    end else begin
      presc    <= presc_nxt;
      idx      <= idx_nxt;
      disp_reg <= disp_nxt;
      pend_reg <= pend_nxt;
      PENDING  <= pending_nxt;
      FRAME    <= boundary;
      NIBBLE   <= nibble_nxt;
      AN       <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, DIV=4: scan timing, double buffering,
// coincident load, mid-frame reset and leading-zero handling.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic                clk;
  logic                rst;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an;
  logic                pending;
  logic                frame;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .CLK     (clk),
    .RST     (rst),
    .VALUE   (value),
    .LOAD    (load),
    .NIBBLE  (nibble),
    .AN      (an),
    .PENDING (pending),
    .FRAME   (frame)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load_value(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    goto(cyc + 1);
    load  = 1'b0;
    value = 16'($urandom_range(0, 65535));
  endtask

  task automatic push_frame(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] a3, input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3);
    exp_q.push_back({a0, n0});
    exp_q.push_back({a1, n1});
    exp_q.push_back({a2, n2});
    exp_q.push_back({a3, n3});
  endtask

  // scoreboard: call at the first cycle of a frame; checks the middle of each digit's lit window
  task automatic check_frame(input string tag);
    int base;
    logic [7:0] e;
    base = cyc;
    for (int d = 0; d < 4; d++) begin
      goto(base + 4*d + 2);
      e = exp_q.pop_front();
      check($sformatf("%s_d%0d", tag, d), {24'h0, an, nibble}, {24'h0, e});
    end
  endtask

  logic [3:0]  an_tab [0:16];
  logic [16:0] frame_tab;

  initial begin
    an_tab = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
               4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111,
               4'b1111};
    frame_tab = 17'h10000;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // reset state and first frame of scanning with nothing loaded
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_nibble", {28'h0, nibble}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    for (int c = 0; c <= 16; c++) begin
      goto(c);
      check($sformatf("scan_an_c%0d", c), {28'h0, an}, {28'h0, an_tab[c]});
      check($sformatf("scan_frame_c%0d", c), {31'h0, frame}, {31'h0, frame_tab[c]});
      check($sformatf("scan_nib_c%0d", c), {28'h0, nibble}, 32'h0);
    end

    // mid-frame load is held until the boundary
    goto(20);
    load_value(16'h1A3F);
    check("ld_pending", {31'h0, pending}, 32'h1);
    goto(26);
    check("ld_hold_nib_a", {28'h0, nibble}, 32'h0);
    goto(30);
    check("ld_hold_nib_b", {28'h0, nibble}, 32'h0);
    goto(32);
    check("ld_apply_pending", {31'h0, pending}, 32'h0);
    check("ld_frame", {31'h0, frame}, 32'h1);
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'hF, 4'h3, 4'hA, 4'h1);
    check_frame("ld_1a3f");

    // two loads in one frame: last write wins
    goto(49);
    load_value(16'h1111);
    check("dbl_pending", {31'h0, pending}, 32'h1);
    goto(55);
    load_value(16'h2222);
    goto(58);
    check("dbl_hold_nib", {28'h0, nibble}, 32'hA);
    goto(64);
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h2, 4'h2, 4'h2, 4'h2);
    check_frame("dbl_2222");

    // load coincident with the boundary beats the older pending value
    goto(84);
    load_value(16'h9999);
    check("coin_pending_a", {31'h0, pending}, 32'h1);
    goto(95);
    load_value(16'h5555);
    check("coin_pending_b", {31'h0, pending}, 32'h0);
    check("coin_frame", {31'h0, frame}, 32'h1);
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h5, 4'h5, 4'h5, 4'h5);
    check_frame("coin_f1");
    goto(112);
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h5, 4'h5, 4'h5, 4'h5);
    check_frame("coin_f2");

    // reset at idx=2 with a value pending
    goto(129);
    load_value(16'h7777);
    goto(137);
    check("mrst_pre_pending", {31'h0, pending}, 32'h1);
    rst = 1'b1;
    goto(138);
    rst = 1'b0;
    check("mrst_an", {28'h0, an}, 32'hF);
    check("mrst_nibble", {28'h0, nibble}, 32'h0);
    check("mrst_pending", {31'h0, pending}, 32'h0);
    check("mrst_frame", {31'h0, frame}, 32'h0);
    cyc = 0;
    goto(2);
    check("mrst_restart_an", {28'h0, an}, 32'hE);
    goto(16);
    check("mrst_frame2_pending", {31'h0, pending}, 32'h0);
    check("mrst_frame2_frame", {31'h0, frame}, 32'h1);
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0);
    check_frame("mrst_blank");

    // leading zeros
    goto(36);
    load_value(16'h0070);
    goto(48);
`ifdef SEG7_LZ_BLANK_EN
    push_frame(4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'h0, 4'h7, 4'h0, 4'h0);
`else
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h0, 4'h7, 4'h0, 4'h0);
`endif
    check_frame("lz_0070");
    goto(68);
    load_value(16'h0000);
    goto(80);
`ifdef SEG7_LZ_BLANK_EN
    push_frame(4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
`else
    push_frame(4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0);
`endif
    check_frame("lz_0000");

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
